execute_stage: RTL and testbench

//  EX stage of the 5-stage MIPS pipeline: ALU control decode, ALU, dest-register mux, branch-target adder, EX/MEM latch.

---
 rtl/execute_stage_pkg.sv | 38 +++
 rtl/execute_stage_ex_mem.sv | 100 ++++++++++
 rtl/execute_stage.sv | 134 +++++++++++++
 tb/tb_execute_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared MIPS EX-stage definitions: aluop/funct codes, internal ALU selects,
// control-bit indices and the signed-overflow helper.
package execute_stage_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_ZERO = 3'd5
  } alu_sel_e;

  // Two's-complement overflow from operand/result sign bits; sub flips the B sign.
  function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/execute_stage_ex_mem.sv
// EX/MEM pipeline latch: async reset clears everything; flush inserts a bubble
// (controls cleared, data loads) and wins over stall, which holds all fields.
module execute_stage_ex_mem #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [1:0]    wb_i,
  input  logic [2:0]    m_i,
  input  logic [DW-1:0] target_i,
  input  logic          zero_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] rdata2_i,
  input  logic [RW-1:0] dest_i,
  input  logic          ovf_i,
  output logic [1:0]    wb_o,
  output logic [2:0]    m_o,
  output logic [DW-1:0] target_o,
  output logic          zero_o,
  output logic [DW-1:0] alu_o,
  output logic [DW-1:0] rdata2_o,
  output logic [RW-1:0] dest_o,
  output logic          ovf_o
);

  logic [1:0]    wb_q,     wb_d;
  logic [2:0]    m_q,      m_d;
  logic [DW-1:0] target_q, target_d;
  logic          zero_q,   zero_d;
  logic [DW-1:0] alu_q,    alu_d;
  logic [DW-1:0] rdata2_q, rdata2_d;
  logic [RW-1:0] dest_q,   dest_d;
  logic          ovf_q,    ovf_d;

  // Next-state: bubble on flush, hold on stall, otherwise load.
  always_comb begin
    wb_d     = wb_q;
    m_d      = m_q;
    target_d = target_q;
    zero_d   = zero_q;
    alu_d    = alu_q;
    rdata2_d = rdata2_q;
    dest_d   = dest_q;
    ovf_d    = ovf_q;
    if (flush_i || !stall_i) begin
      target_d = target_i;
      zero_d   = zero_i;
      alu_d    = alu_i;
      rdata2_d = rdata2_i;
      dest_d   = dest_i;
      if (flush_i) begin
        wb_d  = 2'b00;
        m_d   = 3'b000;
        ovf_d = 1'b0;
      end else begin
        wb_d  = wb_i;
        m_d   = m_i;
        ovf_d = ovf_i;
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Latch registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q     <= 2'b00;
      m_q      <= 3'b000;
      target_q <= {DW{1'b0}};
      zero_q   <= 1'b0;
      alu_q    <= {DW{1'b0}};
      rdata2_q <= {DW{1'b0}};
      dest_q   <= {RW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      target_q <= target_d;
      zero_q   <= zero_d;
      alu_q    <= alu_d;
      rdata2_q <= rdata2_d;
      dest_q   <= dest_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wb_o     = wb_q;
  assign m_o      = m_q;
  assign target_o = target_q;
  assign zero_o   = zero_q;
  assign alu_o    = alu_q;
  assign rdata2_o = rdata2_q;
  assign dest_o   = dest_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: ALU control, ALU, dest mux, branch-target adder, EX/MEM latch.
// Optional EXECUTE_OVF_TRAP_EN: signed overflow on funct add/sub sets ovf and suppresses regwrite.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    wb_ctl,
  input  logic [2:0]    m_ctl,
  input  logic          regdst,
  input  logic          alusrc,
  input  logic [1:0]    aluop,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] sign_ext,
  input  logic [RW-1:0] instr_2016,
  input  logic [RW-1:0] instr_1511,
  output logic [1:0]    wb_ctlout,
  output logic          branch,
  output logic          memread,
  output logic          memwrite,
  output logic [DW-1:0] add_result,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] rdata2out,
  output logic [RW-1:0] five_bit_muxout,
  output logic          ovf
);

  alu_sel_e      alu_sel_s;
  logic [DW-1:0] operand_b_s;
  logic [DW-1:0] sum_s;
  logic [DW-1:0] diff_s;
  logic [DW-1:0] alu_res_s;
  logic          zero_s;
  logic [RW-1:0] dest_s;
  logic [DW-1:0] target_s;
  logic          ovf_s;
  logic [1:0]    wb_ex_s;
  logic [2:0]    m_out_s;

  // ALU control: reserved aluop and unknown funct map to a forced-zero result.
  always_comb begin
    alu_sel_s = ALU_ZERO;
    case (aluop)
      ALUOP_ADD: alu_sel_s = ALU_ADD;
      ALUOP_SUB: alu_sel_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (sign_ext[5:0])
          FUNCT_ADD: alu_sel_s = ALU_ADD;
          FUNCT_SUB: alu_sel_s = ALU_SUB;
          FUNCT_AND: alu_sel_s = ALU_AND;
          FUNCT_OR:  alu_sel_s = ALU_OR;
          FUNCT_SLT: alu_sel_s = ALU_SLT;
          default:   alu_sel_s = ALU_ZERO;
        endcase
      end
      default: alu_sel_s = ALU_ZERO;
    endcase
  end

  assign operand_b_s = alusrc ? sign_ext : rdata2;
  assign sum_s       = rdata1 + operand_b_s;
  assign diff_s      = rdata1 - operand_b_s;

  // ALU datapath.
  always_comb begin
    alu_res_s = {DW{1'b0}};
    case (alu_sel_s)
      ALU_ADD:  alu_res_s = sum_s;
      ALU_SUB:  alu_res_s = diff_s;
      ALU_AND:  alu_res_s = rdata1 & operand_b_s;
      ALU_OR:   alu_res_s = rdata1 | operand_b_s;
      ALU_SLT:  alu_res_s = {{(DW-1){1'b0}}, ($signed(rdata1) < $signed(operand_b_s))};
      default:  alu_res_s = {DW{1'b0}};
    endcase
  end

  assign zero_s   = (alu_res_s == {DW{1'b0}});
  assign dest_s   = regdst ? instr_1511 : instr_2016;
  assign target_s = npc + (sign_ext << 2);

`ifdef EXECUTE_OVF_TRAP_EN
  // Only R-type add/sub trap; lw/sw/beq address and compare math never does.
  always_comb begin
    ovf_s = 1'b0;
    if (aluop == ALUOP_FUNCT && alu_sel_s == ALU_ADD) begin
      ovf_s = signed_ovf(1'b0, rdata1[DW-1], operand_b_s[DW-1], sum_s[DW-1]);
    end else if (aluop == ALUOP_FUNCT && alu_sel_s == ALU_SUB) begin
      ovf_s = signed_ovf(1'b1, rdata1[DW-1], operand_b_s[DW-1], diff_s[DW-1]);
    end else begin
      ovf_s = 1'b0;
    end
  end
  assign wb_ex_s = {wb_ctl[WB_REGWRITE] & ~ovf_s, wb_ctl[WB_MEMTOREG]};
`else
  assign ovf_s   = 1'b0;
  assign wb_ex_s = wb_ctl;
`endif

  execute_stage_ex_mem #(.DW(DW), .RW(RW)) u_ex_mem (
    .clk_i    (clk),
    .rst_i    (rst),
    .stall_i  (stall),
    .flush_i  (flush),
    .wb_i     (wb_ex_s),
    .m_i      (m_ctl),
    .target_i (target_s),
    .zero_i   (zero_s),
    .alu_i    (alu_res_s),
    .rdata2_i (rdata2),
    .dest_i   (dest_s),
    .ovf_i    (ovf_s),
    .wb_o     (wb_ctlout),
    .m_o      (m_out_s),
    .target_o (add_result),
    .zero_o   (zero),
    .alu_o    (alu_result),
    .rdata2_o (rdata2out),
    .dest_o   (five_bit_muxout),
    .ovf_o    (ovf)
  );

  assign branch   = m_out_s[M_BRANCH];
  assign memread  = m_out_s[M_MEMREAD];
  assign memwrite = m_out_s[M_MEMWRITE];

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, regdst, alusrc;
  logic [1:0]  wb_ctl, aluop;
  logic [2:0]  m_ctl;
  logic [31:0] npc, rdata1, rdata2, sign_ext;
  logic [4:0]  instr_2016, instr_1511;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero, ovf;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [31:0] e_add, e_alu, e_rd2;
  logic        e_zero, e_ovf;
  logic [4:0]  e_dst;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc), .aluop(aluop),
    .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .sign_ext(sign_ext),
    .instr_2016(instr_2016), .instr_1511(instr_1511),
    .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread), .memwrite(memwrite),
    .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout), .ovf(ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU using signed 64-bit arithmetic.
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output logic ov);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    ov = 1'b0;
    if (op == 2'd0) r = sa + sb;
    else if (op == 2'd1) r = sa - sb;
    else if (op == 2'd2) begin
      if (f == 6'd32) begin r = sa + sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      else if (f == 6'd34) begin r = sa - sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      else if (f == 6'd36) r = longint'(a & b);
      else if (f == 6'd37) r = longint'(a | b);
      else if (f == 6'd42) r = (sa < sb) ? 1 : 0;
      else r = 0;
    end
    return r[31:0];
  endfunction

  task automatic model_edge();
    logic [31:0] b, res;
    logic        ov, trap;
    b   = alusrc ? sign_ext : rdata2;
    res = ref_alu(aluop, sign_ext[5:0], rdata1, b, ov);
`ifdef EXECUTE_OVF_TRAP_EN
    trap = ov;
`else
    trap = 1'b0;
`endif
    if (flush || !stall) begin
      e_add  = npc + sign_ext * 32'd4;
      e_alu  = res;
      e_zero = (res == 32'd0);
      e_rd2  = rdata2;
      e_dst  = regdst ? instr_1511 : instr_2016;
      if (flush) begin
        e_wb = 2'b00; e_m = 3'b000; e_ovf = 1'b0;
      end else begin
        e_wb = {wb_ctl[1] & ~trap, wb_ctl[0]}; e_m = m_ctl; e_ovf = trap;
      end
    end
  endtask

  task automatic model_clear();
    e_wb = 2'b00; e_m = 3'b000; e_add = 32'd0; e_alu = 32'd0;
    e_zero = 1'b0; e_rd2 = 32'd0; e_dst = 5'd0; e_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".wb"},   {30'd0, wb_ctlout}, {30'd0, e_wb});
    check_val({tag, ".m"},    {29'd0, branch, memread, memwrite}, {29'd0, e_m});
    check_val({tag, ".add"},  add_result, e_add);
    check_val({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
    check_val({tag, ".alu"},  alu_result, e_alu);
    check_val({tag, ".rd2"},  rdata2out, e_rd2);
    check_val({tag, ".dst"},  {27'd0, five_bit_muxout}, {27'd0, e_dst});
    check_val({tag, ".ovf"},  {31'd0, ovf}, {31'd0, e_ovf});
  endtask

  // Update model, advance one edge, compare just after it.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    aluop = op; rdata1 = a; rdata2 = b;
    sign_ext = {sign_ext[31:6], f};
  endtask

  task automatic rand_inputs();
    logic [5:0] functs [5];
    functs[0] = 6'd32; functs[1] = 6'd34; functs[2] = 6'd36; functs[3] = 6'd37; functs[4] = 6'd42;
    wb_ctl = 2'($urandom); m_ctl = 3'($urandom);
    regdst = 1'($urandom); alusrc = 1'($urandom); aluop = 2'($urandom);
    npc = $urandom; instr_2016 = 5'($urandom); instr_1511 = 5'($urandom);
    rdata1 = $urandom; rdata2 = $urandom; sign_ext = $urandom;
    if ($urandom_range(0, 9) < 8) sign_ext[5:0] = functs[$urandom_range(0, 4)];
    case ($urandom_range(0, 5))
      0: rdata2 = rdata1;
      1: begin rdata1 = 32'h7FFFFFFF; rdata2 = 32'd1 + 32'($urandom_range(0, 3)); end
      2: begin rdata1 = 32'h80000000; rdata2 = 32'hFFFFFFFF; end
      default: ;
    endcase
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0; rst = 1'b1;
    rand_inputs();
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk); rst = 1'b0;

    // R-type add to rd
    wb_ctl = 2'b10; m_ctl = 3'b000; regdst = 1'b1; alusrc = 1'b0; instr_1511 = 5'd9;
    set_op(2'b10, 6'b100000, 32'd5, 32'd7);
    cycle("radd");
    check_val("radd.const", alu_result, 32'd12);
    check_val("radd.dst_const", {27'd0, five_bit_muxout}, 32'd9);

    // beq taken
    wb_ctl = 2'b00; m_ctl = 3'b100; npc = 32'h40; sign_ext = 32'd3;
    set_op(2'b01, 6'd3, 32'h1234, 32'h1234);
    cycle("beq");
    check_val("beq.target_const", add_result, 32'h4C);
    check_val("beq.zero_const", {31'd0, zero}, 32'd1);

    // lw address
    wb_ctl = 2'b11; m_ctl = 3'b010; alusrc = 1'b1; regdst = 1'b0; instr_2016 = 5'd4;
    sign_ext = 32'hFFFFFFFC; aluop = 2'b00; rdata1 = 32'h100;
    cycle("lw");
    check_val("lw.alu_const", alu_result, 32'hFC);

    // slt both directions
    alusrc = 1'b0; m_ctl = 3'b000; wb_ctl = 2'b10;
    set_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    cycle("slt_lt");
    check_val("slt_lt.const", alu_result, 32'd1);
    set_op(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF);
    cycle("slt_ge");
    check_val("slt_ge.const", alu_result, 32'd0);

    // reserved aluop and bad funct force zero
    set_op(2'b11, 6'b100000, 32'd3, 32'd4);
    cycle("resv");
    set_op(2'b10, 6'b000111, 32'd3, 32'd4);
    cycle("badfunct");

    // overflow add
    set_op(2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1);
    cycle("ovf_add");

    // stall three cycles with changing inputs
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle("stall3");
    end
    // flush with stall -> bubble, then stall-only holds the bubble
    wb_ctl = 2'b11; m_ctl = 3'b111; flush = 1'b1;
    cycle("flush_stall");
    flush = 1'b0; rand_inputs();
    cycle("hold_bubble");

    // async reset mid-stall
    wb_ctl = 2'b11; m_ctl = 3'b111; stall = 1'b0;
    cycle("preload");
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_all("rst_async");
    @(posedge clk); #1;
    check_all("rst_held");
    @(negedge clk); rst = 1'b0; stall = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 1);
      cycle("rand");
      #3;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
